oled_bus: RTL and testbench

- Parametrised HD44780/WS0010-style parallel bus engine for character/graphic OLEDs; next generation of the single-mode OLED bus driver.
- Adds a selectable 8-bit or 4-bit bus and programmable setup/pulse/hold timing in clocks.
- Adds data/status read-back with a response handshake, plus a busy-poll timeout with a sticky error flag.
- Sits between command sources (init/graphics sequencers) and the SB_IO tristate pad wrapper; it drives db_out/db_oe and samples db_in.

---
 rtl/oled_bus_pkg.sv | 20 ++
 rtl/oled_bus_if.sv | 20 ++
 rtl/oled_bus_strobe.sv | 57 +++++
 rtl/oled_bus.sv | 114 +++++++++++
 tb/tb_oled_bus.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_bus_pkg.sv
// oled_bus_pkg: shared state encodings, pin encodings and timing defaults for the OLED bus engine
package oled_bus_pkg;
    typedef enum logic [1:0] {IDLE, CMD, POLL} mode_t;
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_PULSE, PH_HOLD} phase_t;
    localparam int DEF_BUS_WIDTH = 8;
    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_PULSE_CYCLES = 1;
    localparam int DEF_HOLD_CYCLES = 1;
    localparam int DEF_BUSY_TIMEOUT = 4096;
    localparam logic RS_INSTR = 1'b0;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ = 1'b1;
    // DB7 sits in the top bit of whatever slice of the bus is wired
    function automatic int busy_idx(input int bus_width);
        return bus_width - 1;
    endfunction
    function automatic int max3(input int a, input int b, input int c);
        return (a > b ? (a > c ? a : c) : (b > c ? b : c));
    endfunction
endpackage

// File: rtl/oled_bus_if.sv
// oled_bus_if: command/response handshake between a sequencer and the bus engine
interface oled_bus_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic       cmd_rw;
    logic [7:0] cmd_data;
    logic       cmd_wait_busy;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy_timeout;
    modport master (
        output cmd_valid, cmd_rs, cmd_rw, cmd_data, cmd_wait_busy,
        input  cmd_ready, rsp_valid, rsp_data, busy_timeout
    );
    modport slave (
        input  cmd_valid, cmd_rs, cmd_rw, cmd_data, cmd_wait_busy,
        output cmd_ready, rsp_valid, rsp_data, busy_timeout
    );
endinterface

// File: rtl/oled_bus_strobe.sv
// oled_bus_strobe: runs one setup/pulse/hold bus transfer and drives the pins
module oled_bus_strobe
    import oled_bus_pkg::*;
#(
    parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 rs,
    input  logic                 rw,
    input  logic [BUS_WIDTH-1:0] data,
    output logic                 rs_pin,
    output logic                 read_pin,
    output logic                 enable_pin,
    output logic [BUS_WIDTH-1:0] db_out,
    output logic                 db_oe,
    output logic                 sample,
    output logic                 done
);
    localparam int CW = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES) + 1);
    phase_t phase, nxt;
    logic [CW-1:0] cnt;
    logic last;
    // end of the current phase and the phase that follows it; start wins so transfers chain back to back
    always_comb begin
        last = phase == PH_IDLE || cnt == (phase == PH_SETUP ? CW'(SETUP_CYCLES - 1) :
                                           phase == PH_PULSE ? CW'(PULSE_CYCLES - 1) : CW'(HOLD_CYCLES - 1));
        nxt = start ? PH_SETUP : !last ? phase :
              phase == PH_SETUP ? PH_PULSE : phase == PH_PULSE ? PH_HOLD : PH_IDLE;
    end
    // phase register and pin latches; reset parks in the setup of a busy poll
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase    <= PH_SETUP;
            cnt      <= '0;
            rs_pin   <= RS_INSTR;
            read_pin <= RW_READ;
            db_out   <= '0;
        end else begin
            phase <= nxt;
            cnt   <= (start || last) ? '0 : cnt + 1'b1;
            if (start) begin
                rs_pin   <= rs;
                read_pin <= rw;
                db_out   <= data;
            end
        end
    end
    assign enable_pin = phase == PH_PULSE;
    assign db_oe      = read_pin == RW_WRITE;
    assign sample     = phase == PH_PULSE && last;
    assign done       = phase == PH_HOLD && last;
endmodule

// File: rtl/oled_bus.sv
// oled_bus: HD44780/WS0010 parallel bus engine with 8/4-bit modes, read-back and busy polling
module oled_bus
    import oled_bus_pkg::*;
#(
    parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    oled_bus_if.slave            bus,
    output logic                 rs_pin,
    output logic                 read_pin,
    output logic                 enable_pin,
    output logic [BUS_WIDTH-1:0] db_out,
    output logic                 db_oe,
    input  logic [BUS_WIDTH-1:0] db_in
);
    localparam int PW = $clog2(BUSY_TIMEOUT + 1);
    localparam bit NIB = BUS_WIDTH == 4;
    mode_t state, nxt;
    logic c_rs, c_rw, c_wait, nib, busy, start, st_rs, st_rw, sample, done, last_nib, timeout, rd_done;
    logic [7:0] c_data, rd_sh;
    logic [BUS_WIDTH-1:0] st_data;
    logic [PW-1:0] poll_cnt;

    assign last_nib      = !NIB || nib;
    assign rd_done       = done && last_nib && state == CMD && c_rw;
    assign bus.cmd_ready = state == IDLE;

    // sequencing: accept, second nibble, optional busy poll, retry or timeout
    always_comb begin
        nxt     = state;
        start   = 1'b0;
        st_rs   = c_rs;
        st_rw   = c_rw;
        st_data = c_data[BUS_WIDTH-1:0];
        timeout = 1'b0;
        if (state == IDLE && bus.cmd_valid) begin
            nxt     = CMD;
            start   = 1'b1;
            st_rs   = bus.cmd_rs;
            st_rw   = bus.cmd_rw;
            st_data = bus.cmd_data[7 -: BUS_WIDTH];
        end else if (done && !last_nib) begin
            start = 1'b1;
        end else if (done && state == CMD && c_wait) begin
            nxt     = POLL;
            start   = 1'b1;
            st_rs   = RS_INSTR;
            st_rw   = RW_READ;
            st_data = '0;
        end else if (done && state == CMD) begin
            nxt = IDLE;
        end else if (done && busy && poll_cnt != PW'(BUSY_TIMEOUT - 1)) begin
            start = 1'b1;
        end else if (done) begin
            nxt     = IDLE;
            timeout = busy;
        end
    end

    // mode register; reset forces a busy poll before the first command
    always_ff @(posedge clk) begin
        if (!reset) state <= POLL;
        else state <= nxt;
    end

    // command capture, nibble index, read assembly, poll count and sticky timeout
    always_ff @(posedge clk) begin
        if (!reset) begin
            c_rs             <= RS_INSTR;
            c_rw             <= RW_READ;
            c_data           <= '0;
            c_wait           <= 1'b0;
            nib              <= 1'b0;
            busy             <= 1'b0;
            poll_cnt         <= '0;
            rd_sh            <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_data     <= '0;
            bus.busy_timeout <= 1'b0;
        end else begin
            if (state == IDLE && bus.cmd_valid) begin
                c_rs   <= bus.cmd_rs;
                c_rw   <= bus.cmd_rw;
                c_data <= bus.cmd_data;
                c_wait <= bus.cmd_wait_busy;
            end else if (state == CMD && nxt == POLL) begin
                c_rs   <= RS_INSTR;
                c_rw   <= RW_READ;
                c_data <= '0;
            end
            if (done) nib <= NIB && !nib;
            if (sample) rd_sh <= 8'({rd_sh, db_in});
            if (sample && state == POLL && !nib) busy <= db_in[busy_idx(BUS_WIDTH)];
            poll_cnt <= state != POLL ? '0 : (done && last_nib && busy) ? poll_cnt + 1'b1 : poll_cnt;
            bus.rsp_valid <= rd_done;
            if (rd_done) bus.rsp_data <= rd_sh;
            if (timeout) bus.busy_timeout <= 1'b1;
        end
    end

    oled_bus_strobe #(
        .BUS_WIDTH(BUS_WIDTH), .SETUP_CYCLES(SETUP_CYCLES),
        .PULSE_CYCLES(PULSE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES)
    ) u_strobe (
        .clk(clk), .reset(reset), .start(start), .rs(st_rs), .rw(st_rw), .data(st_data),
        .rs_pin(rs_pin), .read_pin(read_pin), .enable_pin(enable_pin),
        .db_out(db_out), .db_oe(db_oe), .sample(sample), .done(done)
    );
endmodule

// File: tb/tb_oled_bus.sv
// tb_oled_bus: scoreboard bench for an 8-bit and a 4-bit oled_bus instance
module tb_oled_bus;
    typedef struct packed {logic rs; logic rw; logic oe; logic [7:0] d; logic chk;} pulse_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_err = 0;

    oled_bus_if b8();
    oled_bus_if b4();
    logic rs8, rd8, en8, oe8, rs4, rd4, en4, oe4;
    logic [7:0] do8, di8;
    logic [3:0] do4, di4;

    int busy_left8 = 0;
    bit stuck8 = 1'b0;
    bit nib4m = 1'b0;
    int polls8 = 0, polls4 = 0;
    int w8 = 0, w4 = 0;
    logic en8_q = 1'b0, en4_q = 1'b0, rv8_q = 1'b0, rv4_q = 1'b0;
    pulse_t e8, e4;
    pulse_t q8[$], q4[$];
    logic [7:0] qr8[$], qr4[$];

    always #5 clk = ~clk;

    assign di8 = rs8 ? 8'h5A : {stuck8 || busy_left8 != 0, 7'h00};
    assign di4 = rs4 ? (nib4m ? 4'h6 : 4'h9) : 4'h0;

    oled_bus #(.BUS_WIDTH(8), .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1), .BUSY_TIMEOUT(8)) dut8 (
        .clk(clk), .reset(reset), .bus(b8), .rs_pin(rs8), .read_pin(rd8), .enable_pin(en8),
        .db_out(do8), .db_oe(oe8), .db_in(di8)
    );
    oled_bus #(.BUS_WIDTH(4), .SETUP_CYCLES(2), .PULSE_CYCLES(3), .HOLD_CYCLES(1), .BUSY_TIMEOUT(4096)) dut4 (
        .clk(clk), .reset(reset), .bus(b4), .rs_pin(rs4), .read_pin(rd4), .enable_pin(en4),
        .db_out(do4), .db_oe(oe4), .db_in(di4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string act, input string exp);
        n_chk++;
        n_err++;
        $display("FAIL %s: got %s expected %s", nm, act, exp);
    endtask

    function automatic pulse_t mk(input logic rs, input logic rw, input logic oe, input logic [7:0] d, input logic c);
        return '{rs: rs, rw: rw, oe: oe, d: d, chk: c};
    endfunction

    // pulse and response monitor for the 8-bit engine
    always @(negedge clk) begin
        if (en8 && !en8_q) begin
            if (q8.size() == 0) fail("pulse8", "extra E pulse", "none");
            else begin
                e8 = q8.pop_front();
                chk("pulse8_rs", rs8, e8.rs);
                chk("pulse8_rw", rd8, e8.rw);
                chk("pulse8_oe", oe8, e8.oe);
                if (e8.chk) chk("pulse8_data", do8, e8.d);
            end
            if (!rs8 && rd8) polls8++;
            w8 = 1;
        end else if (en8) w8++;
        if (!en8 && en8_q) begin
            if (reset) chk("pulse8_width", w8, 1);
            if (!rs8 && rd8 && busy_left8 > 0) busy_left8--;
        end
        if (b8.rsp_valid) begin
            if (rv8_q) fail("rsp8_len", "valid 2+ cycles", "1 cycle");
            if (qr8.size() == 0) fail("rsp8", "unexpected rsp_valid", "none");
            else chk("rsp8_data", b8.rsp_data, qr8.pop_front());
        end
        en8_q = en8;
        rv8_q = b8.rsp_valid;
    end

    // pulse and response monitor for the 4-bit engine
    always @(negedge clk) begin
        if (en4 && !en4_q) begin
            if (q4.size() == 0) fail("pulse4", "extra E pulse", "none");
            else begin
                e4 = q4.pop_front();
                chk("pulse4_rs", rs4, e4.rs);
                chk("pulse4_rw", rd4, e4.rw);
                chk("pulse4_oe", oe4, e4.oe);
                if (e4.chk) chk("pulse4_data", {4'h0, do4}, e4.d);
            end
            if (!rs4 && rd4) polls4++;
            w4 = 1;
        end else if (en4) w4++;
        if (!en4 && en4_q) begin
            if (reset) chk("pulse4_width", w4, 3);
            if (rs4 && rd4) nib4m = !nib4m;
        end
        if (b4.rsp_valid) begin
            if (rv4_q) fail("rsp4_len", "valid 2+ cycles", "1 cycle");
            if (qr4.size() == 0) fail("rsp4", "unexpected rsp_valid", "none");
            else chk("rsp4_data", b4.rsp_data, qr4.pop_front());
        end
        en4_q = en4;
        rv4_q = b4.rsp_valid;
    end

    task automatic send(input bit four, input logic rs, input logic rw, input logic [7:0] d, input logic wb);
        int k = 0;
        while (!(four ? b4.cmd_ready : b8.cmd_ready) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) fail("send_ready", "timeout", "cmd_ready");
        if (four) begin
            b4.cmd_valid = 1'b1; b4.cmd_rs = rs; b4.cmd_rw = rw; b4.cmd_data = d; b4.cmd_wait_busy = wb;
        end else begin
            b8.cmd_valid = 1'b1; b8.cmd_rs = rs; b8.cmd_rw = rw; b8.cmd_data = d; b8.cmd_wait_busy = wb;
        end
        @(negedge clk);
        if (four) begin
            b4.cmd_valid = 1'b0; b4.cmd_rs = ~rs; b4.cmd_rw = ~rw; b4.cmd_data = ~d; b4.cmd_wait_busy = ~wb;
        end else begin
            b8.cmd_valid = 1'b0; b8.cmd_rs = ~rs; b8.cmd_rw = ~rw; b8.cmd_data = ~d; b8.cmd_wait_busy = ~wb;
        end
    endtask

    task automatic wait_ready(input bit four, output int k, output logic [31:0] h, output logic oe_any);
        k = 1;
        h = '0;
        oe_any = 1'b0;
        while (1) begin
            if (k < 32) h[k] = four ? en4 : en8;
            oe_any = oe_any | (four ? oe4 : oe8);
            if ((four ? b4.cmd_ready : b8.cmd_ready) || k >= 500) break;
            @(negedge clk);
            k++;
        end
        if (k >= 500) fail("wait_ready", "timeout", "cmd_ready");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, p0;
        logic [31:0] h;
        logic o;
        b8.cmd_valid = 0; b8.cmd_rs = 0; b8.cmd_rw = 0; b8.cmd_data = 0; b8.cmd_wait_busy = 0;
        b4.cmd_valid = 0; b4.cmd_rs = 0; b4.cmd_rw = 0; b4.cmd_data = 0; b4.cmd_wait_busy = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready8", b8.cmd_ready, 0);
        chk("rst_en8", en8, 0);
        chk("rst_read8", rd8, 1);
        chk("rst_rs8", rs8, 0);
        chk("rst_db8", do8, 0);
        chk("rst_oe8", oe8, 0);
        chk("rst_rv8", b8.rsp_valid, 0);
        chk("rst_rd8", b8.rsp_data, 0);
        chk("rst_to8", b8.busy_timeout, 0);
        chk("rst_en4", en4, 0);
        q8.push_back(mk(0, 1, 0, 0, 0));
        q4.push_back(mk(0, 1, 0, 0, 0));
        q4.push_back(mk(0, 1, 0, 0, 0));
        reset = 1'b1;
        wait_ready(0, k, h, o);
        wait_ready(1, k, h, o);

        q8.push_back(mk(1, 0, 1, 8'hA5, 1));
        send(0, 1, 0, 8'hA5, 0);
        chk("w8_db_out", do8, 8'hA5);
        chk("w8_oe", oe8, 1);
        wait_ready(0, k, h, o);
        chk("w8_ready_cycle", k, 4);
        chk("w8_e_cycles", h, 32'h4);

        q4.push_back(mk(1, 0, 1, 8'h3, 1));
        q4.push_back(mk(1, 0, 1, 8'hC, 1));
        send(1, 1, 0, 8'h3C, 0);
        wait_ready(1, k, h, o);
        chk("w4_ready_cycle", k, 13);
        chk("w4_e_cycles", h, 32'hE38);

        q8.push_back(mk(1, 1, 0, 0, 0));
        qr8.push_back(8'h5A);
        send(0, 1, 1, 8'h00, 0);
        wait_ready(0, k, h, o);
        chk("r8_oe_any", o, 0);
        chk("r8_ready_cycle", k, 4);

        q4.push_back(mk(1, 1, 0, 0, 0));
        q4.push_back(mk(1, 1, 0, 0, 0));
        qr4.push_back(8'h96);
        send(1, 1, 1, 8'h00, 0);
        wait_ready(1, k, h, o);
        chk("r4_oe_any", o, 0);

        busy_left8 = 3;
        q8.push_back(mk(0, 0, 1, 8'h01, 1));
        repeat (4) q8.push_back(mk(0, 1, 0, 0, 0));
        p0 = polls8;
        send(0, 0, 0, 8'h01, 1);
        wait_ready(0, k, h, o);
        chk("poll_ready_cycle", k, 16);
        chk("poll_count", polls8 - p0, 4);
        chk("poll_to", b8.busy_timeout, 0);

        stuck8 = 1'b1;
        q8.push_back(mk(0, 0, 1, 8'h01, 1));
        repeat (8) q8.push_back(mk(0, 1, 0, 0, 0));
        p0 = polls8;
        send(0, 0, 0, 8'h01, 1);
        wait_ready(0, k, h, o);
        chk("tmo_ready_cycle", k, 28);
        chk("tmo_poll_count", polls8 - p0, 8);
        chk("tmo_flag", b8.busy_timeout, 1);
        stuck8 = 1'b0;
        q8.push_back(mk(1, 0, 1, 8'h42, 1));
        send(0, 1, 0, 8'h42, 0);
        wait_ready(0, k, h, o);
        chk("tmo_sticky", b8.busy_timeout, 1);

        q4.push_back(mk(1, 0, 1, 8'h3, 1));
        send(1, 1, 0, 8'h3C, 0);
        k = 0;
        while (!en4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!en4) fail("abort_pulse", "no E pulse", "E high");
        reset = 1'b0;
        @(negedge clk);
        chk("abort_en", en4, 0);
        chk("abort_read", rd4, 1);
        chk("abort_oe", oe4, 0);
        chk("abort_to8", b8.busy_timeout, 0);
        q8.push_back(mk(0, 1, 0, 0, 0));
        q4.push_back(mk(0, 1, 0, 0, 0));
        q4.push_back(mk(0, 1, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", b4.cmd_ready, 0);
        p0 = polls4;
        wait_ready(1, k, h, o);
        chk("abort_startup_polls", polls4 - p0, 2);
        wait_ready(0, k, h, o);

        repeat (3) @(negedge clk);
        chk("q8_left", q8.size(), 0);
        chk("q4_left", q4.size(), 0);
        chk("qr8_left", qr8.size(), 0);
        chk("qr4_left", qr4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
